// File: rtl/timing_check_monitor_if.sv
// rtl/timing_check_monitor_if.sv - stimulus and violation signal bundle for timing_check_monitor
//
// Signals:
//   en_i          check enable
//   clr_i         synchronous clear of counts and sticky flags
//   data_i        checked data signals, one bit per channel
//   ref_i         reference signals, rising edge is the reference event
//   setup_viol_o  one-cycle setup violation pulses
//   hold_viol_o   one-cycle hold violation pulses
//   skew_viol_o   one-cycle ref-to-ref skew violation pulses
//   sticky_o      latched any-violation flags
//   viol_cnt_o    saturating per-channel counts, channel k at [k*CNT_W +: CNT_W]
// master drives the checked signals, slave is the monitor.
interface timing_check_monitor_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 4
);
    logic                      en_i;
    logic                      clr_i;
    logic [CHANNELS-1:0]       data_i;
    logic [CHANNELS-1:0]       ref_i;
    logic [CHANNELS-1:0]       setup_viol_o;
    logic [CHANNELS-1:0]       hold_viol_o;
    logic [CHANNELS-1:0]       skew_viol_o;
    logic [CHANNELS-1:0]       sticky_o;
    logic [CHANNELS*CNT_W-1:0] viol_cnt_o;

    modport master (
        output en_i, clr_i, data_i, ref_i,
        input  setup_viol_o, hold_viol_o, skew_viol_o, sticky_o, viol_cnt_o
    );

    modport slave (
        input  en_i, clr_i, data_i, ref_i,
        output setup_viol_o, hold_viol_o, skew_viol_o, sticky_o, viol_cnt_o
    );
endinterface

// File: rtl/timing_check_monitor.sv
// rtl/timing_check_monitor.sv - per-channel setup/hold timing check monitor with optional ref skew check
//
// Optional feature: define TIMING_CHECK_MONITOR_SKEW_EN to build the ch0-relative
// ref-to-ref skew checker; otherwise skew_viol_o is tied to zero.
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    timing_check_monitor_if.slave: en_i, clr_i, data_i, ref_i in;
//          setup_viol_o, hold_viol_o, skew_viol_o, sticky_o, viol_cnt_o out
module timing_check_monitor #(
    parameter int CHANNELS  = 4,
    parameter int SETUP_CYC = 3,
    parameter int HOLD_CYC  = 2,
    parameter int SKEW_CYC  = 4,
    parameter int DATA_EDGE = 0,
    parameter int CNT_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    timing_check_monitor_if.slave bus
);
    localparam int AGE_W  = $clog2(SETUP_CYC + 1);
    localparam int HCNT_W = $clog2(HOLD_CYC + 1);

    localparam logic [AGE_W-1:0]  AGE_SAT  = AGE_W'(SETUP_CYC);
    localparam logic [AGE_W-1:0]  AGE_LIM  = AGE_W'(SETUP_CYC - 1);
    localparam logic [HCNT_W-1:0] HOLD_END = HCNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    // An out-of-range configuration leaves the monitor inert rather than
    // checking against silently truncated windows.
    localparam bit PARAMS_OK = (CHANNELS >= 1) && (CHANNELS <= 16)
                            && (SETUP_CYC >= 1) && (SETUP_CYC <= 255)
                            && (HOLD_CYC >= 1) && (HOLD_CYC <= 255)
                            && (SKEW_CYC >= 1) && (SKEW_CYC <= 255)
                            && (DATA_EDGE >= 0) && (DATA_EDGE <= 2)
                            && (CNT_W >= 1);

    typedef enum logic {
        IDLE     = 1'b0,
        HOLD_WIN = 1'b1
    } state_t;

    logic                      armed_q;
    logic [CHANNELS-1:0]       data_prev_q;
    logic [CHANNELS-1:0]       ref_prev_q;
    logic [AGE_W-1:0]          age_q    [CHANNELS];
    logic [AGE_W-1:0]          age_d    [CHANNELS];
    state_t                    state_q  [CHANNELS];
    state_t                    state_d  [CHANNELS];
    logic [HCNT_W-1:0]         hcnt_q   [CHANNELS];
    logic [HCNT_W-1:0]         hcnt_d   [CHANNELS];
    logic [CNT_W-1:0]          cnt_q    [CHANNELS];
    logic [CNT_W-1:0]          cnt_d    [CHANNELS];
    logic [1:0]                inc      [CHANNELS];
    logic [CNT_W+1:0]          sum      [CHANNELS];
    logic [CHANNELS-1:0]       sticky_q;
    logic [CHANNELS-1:0]       sticky_d;
    logic [CHANNELS-1:0]       setup_q;
    logic [CHANNELS-1:0]       hold_q;
    logic                      det_en;
    logic [CHANNELS-1:0]       data_sel;
    logic [CHANNELS-1:0]       data_edge;
    logic [CHANNELS-1:0]       ref_edge;
    logic [CHANNELS-1:0]       in_win;
    logic [CHANNELS-1:0]       setup_det;
    logic [CHANNELS-1:0]       hold_det;
    logic [CHANNELS-1:0]       skew_det;
    logic [CHANNELS*CNT_W-1:0] cnt_flat;

    // Edge detection against the previous sample. armed_q is low for the
    // first cycle after reset so levels present at release are not edges.
    always_comb begin
        if (DATA_EDGE == 1) begin
            data_sel = bus.data_i & ~data_prev_q;
        end else if (DATA_EDGE == 2) begin
            data_sel = ~bus.data_i & data_prev_q;
        end else begin
            data_sel = bus.data_i ^ data_prev_q;
        end
        det_en    = armed_q & bus.en_i & PARAMS_OK;
        data_edge = det_en ? data_sel : '0;
        ref_edge  = det_en ? (bus.ref_i & ~ref_prev_q) : '0;
    end

    // Hold-window FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                state_q[k] <= IDLE;
                hcnt_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                state_q[k] <= state_d[k];
                hcnt_q[k]  <= hcnt_d[k];
            end
        end
    end

    // Hold-window FSM: next state. hcnt counts cycles since the ref edge, so
    // HOLD_WIN spans ref+1 .. ref+HOLD_CYC.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            state_d[k] = state_q[k];
            hcnt_d[k]  = hcnt_q[k];
            if (!bus.en_i) begin
                state_d[k] = IDLE;
                hcnt_d[k]  = '0;
            end else if (ref_edge[k]) begin
                state_d[k] = HOLD_WIN;
                hcnt_d[k]  = HCNT_W'(1);
            end else if (state_q[k] == HOLD_WIN) begin
                if (hcnt_q[k] == HOLD_END) begin
                    state_d[k] = IDLE;
                    hcnt_d[k]  = '0;
                end else begin
                    hcnt_d[k] = hcnt_q[k] + HCNT_W'(1);
                end
            end
        end
    end

    // Hold-window FSM: outputs. age_q reads (cycles since data edge - 1), so
    // age_q < SETUP_CYC-1 means the data edge is within the setup window.
    // A data edge coinciding with a ref edge is a setup violation only.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            in_win[k]    = (state_q[k] == HOLD_WIN);
            setup_det[k] = ref_edge[k] & (data_edge[k] | (age_q[k] < AGE_LIM));
            hold_det[k]  = data_edge[k] & in_win[k] & ~ref_edge[k];
        end
    end

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            if (!bus.en_i) begin
                age_d[k] = AGE_SAT;
            end else if (data_edge[k]) begin
                age_d[k] = '0;
            end else if (age_q[k] < AGE_SAT) begin
                age_d[k] = age_q[k] + AGE_W'(1);
            end else begin
                age_d[k] = age_q[k];
            end
        end
    end

    // Counts add every violation of the cycle at once; clear loads the
    // increment so a violation coinciding with clr_i is not lost.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            inc[k]      = {1'b0, setup_det[k]} + {1'b0, hold_det[k]} + {1'b0, skew_det[k]};
            sum[k]      = (bus.clr_i ? '0 : {2'b00, cnt_q[k]}) + {{CNT_W{1'b0}}, inc[k]};
            cnt_d[k]    = (|sum[k][CNT_W+1:CNT_W]) ? CNT_MAX : sum[k][CNT_W-1:0];
            sticky_d[k] = (bus.clr_i ? 1'b0 : sticky_q[k]) | (|inc[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q     <= 1'b0;
            data_prev_q <= '0;
            ref_prev_q  <= '0;
            sticky_q    <= '0;
            setup_q     <= '0;
            hold_q      <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                age_q[k] <= AGE_SAT;
                cnt_q[k] <= '0;
            end
        end else begin
            armed_q     <= 1'b1;
            data_prev_q <= bus.data_i;
            ref_prev_q  <= bus.ref_i;
            sticky_q    <= sticky_d;
            setup_q     <= setup_det;
            hold_q      <= hold_det;
            for (int k = 0; k < CHANNELS; k++) begin
                age_q[k] <= age_d[k];
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

`ifdef TIMING_CHECK_MONITOR_SKEW_EN
    localparam int SKW_W = $clog2(SKEW_CYC + 1);
    localparam logic [SKW_W-1:0] SKW_END = SKW_W'(SKEW_CYC);

    logic                skw_open_q;
    logic                skw_open_d;
    logic [SKW_W-1:0]    skw_cnt_q;
    logic [SKW_W-1:0]    skw_cnt_d;
    logic [CHANNELS-1:0] skw_seen_q;
    logic [CHANNELS-1:0] skw_seen_d;
    logic [CHANNELS-1:0] skw_seen_all;
    logic [CHANNELS-1:0] skew_q;

    // A ch0 ref edge opens a window t0..t0+SKEW_CYC; skw_cnt_q holds the
    // offset from t0. Edges in the final cycle still count. A fresh ch0
    // edge restarts the window and discards the one in progress.
    always_comb begin
        skw_open_d   = skw_open_q;
        skw_cnt_d    = skw_cnt_q;
        skw_seen_d   = skw_seen_q;
        skw_seen_all = skw_seen_q | ref_edge;
        skew_det     = '0;
        if (!bus.en_i) begin
            skw_open_d = 1'b0;
            skw_cnt_d  = '0;
            skw_seen_d = '0;
        end else if (ref_edge[0]) begin
            skw_open_d = 1'b1;
            skw_cnt_d  = SKW_W'(1);
            skw_seen_d = ref_edge;
        end else if (skw_open_q) begin
            if (skw_cnt_q == SKW_END) begin
                skew_det    = ~skw_seen_all;
                skew_det[0] = 1'b0;
                skw_open_d  = 1'b0;
                skw_cnt_d   = '0;
                skw_seen_d  = '0;
            end else begin
                skw_cnt_d  = skw_cnt_q + SKW_W'(1);
                skw_seen_d = skw_seen_all;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skw_open_q <= 1'b0;
            skw_cnt_q  <= '0;
            skw_seen_q <= '0;
            skew_q     <= '0;
        end else begin
            skw_open_q <= skw_open_d;
            skw_cnt_q  <= skw_cnt_d;
            skw_seen_q <= skw_seen_d;
            skew_q     <= skew_det;
        end
    end

    assign bus.skew_viol_o = skew_q;
`else
    assign skew_det        = '0;
    assign bus.skew_viol_o = '0;
`endif

    always_comb begin
        cnt_flat = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cnt_flat[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end

    assign bus.setup_viol_o = setup_q;
    assign bus.hold_viol_o  = hold_q;
    assign bus.sticky_o     = sticky_q;
    assign bus.viol_cnt_o   = cnt_flat;
endmodule

// File: doc/timing_check_monitor.md
TIMING_CHECK_MONITOR -- requirements
Module: timing_check_monitor

Interface
REQ-001 Parameters SHALL be: CHANNELS, 4, number of independent check channels (1..16).
REQ-002 Parameters SHALL be: SETUP_CYC, 3, setup window in clk cycles (1..255).
REQ-003 Parameters SHALL be: HOLD_CYC, 2, hold window in clk cycles (1..255).
REQ-004 Parameters SHALL be: SKEW_CYC, 4, max ref-to-ref skew in clk cycles (1..255).
REQ-005 Parameters SHALL be: DATA_EDGE, 0, data edge selector (0 = any, 1 = rise, 2 = fall).
REQ-006 Parameters SHALL be: CNT_W, 4, width of each per-channel violation counter.
REQ-007 Ports SHALL be: clk  in  1  single clock, rising edge.
REQ-008 Ports SHALL be: rst_n  in  1  reset, asynchronous, active-low.
REQ-009 Ports SHALL be: en_i  in  1  check enable.
REQ-010 Ports SHALL be: clr_i  in  1  synchronous clear of counters and sticky flags.
REQ-011 Ports SHALL be: data_i  in  CHANNELS  checked data signals, synchronous to clk.
REQ-012 Ports SHALL be: ref_i  in  CHANNELS  reference signals; the rising edge is the reference event.
REQ-013 Ports SHALL be: setup_viol_o, hold_viol_o  out  CHANNELS  one-cycle violation pulses.
REQ-014 Ports SHALL be: sticky_o  out  CHANNELS  latched any-violation flag.
REQ-015 Ports SHALL be: viol_cnt_o  out  CHANNELS*CNT_W  saturating counts; channel k occupies bits [k*CNT_W +: CNT_W].
REQ-016 Ports SHALL be: skew_viol_o  out  CHANNELS  one-cycle skew violation pulses.

Function
REQ-017 Edges SHALL be detected by comparing the current sample with a registered previous sample; the detection cycle is the first cycle the new value is seen.
REQ-018 Each channel SHALL run a 2-state FSM: IDLE, then HOLD_WIN on a ref edge; it SHALL return to IDLE after HOLD_CYC cycles, and a new ref edge in HOLD_WIN SHALL restart the window.
REQ-019 A per-channel age counter SHALL be zeroed on a data edge, increment otherwise, and saturate at SETUP_CYC.
REQ-020 Setup violation: a ref edge at cycle t_r with the last data edge at t_d, where 0 <= t_r - t_d < SETUP_CYC.
REQ-021 Hold violation: a data edge at t_d while in HOLD_WIN, where 1 <= t_d - t_r <= HOLD_CYC.
REQ-022 Data and ref edges in the same cycle SHALL give a setup violation only.
REQ-023 Violation pulses SHALL be registered and appear at detection cycle + 1.
REQ-024 Each violation SHALL increment its channel count by 1, saturating at 2^CNT_W-1, and SHALL set sticky_o.
REQ-025 A simultaneous setup and hold violation SHALL increment the count by 2, still saturating.
REQ-026 When clr_i coincides with a violation, the count SHALL load the new increment and sticky_o SHALL remain set.
REQ-027 When en_i = 0: no detection, FSMs forced to IDLE, age saturated, edge sample registers still updated, counts held.

Reset
REQ-028 During reset, all outputs, counts, sticky flags, FSMs (IDLE) and skew windows SHALL be zero, and age SHALL be saturated.
REQ-029 In the first cycle after rst_n deasserts, edge detection SHALL be suppressed; the previous-sample registers are loaded from the inputs, so levels present at release produce no edge.
REQ-030 Asserting rst_n mid-window SHALL abort the window; no violation from it SHALL be reported after release.

Configuration
REQ-031 With macro TIMING_CHECK_MONITOR_SKEW_EN defined, a ch0 ref edge at t0 SHALL open a skew window covering t0..t0+SKEW_CYC.
REQ-032 With the macro defined, each channel k>0 lacking a ref edge in that window SHALL pulse skew_viol_o[k] at t0+SKEW_CYC+1, increment its count and set sticky_o.
REQ-033 With the macro defined, a new ch0 edge SHALL restart the window, and ch k edges with no open window SHALL be ignored.
REQ-034 Without the macro, skew_viol_o SHALL be tied to 0 and no skew logic SHALL be built; skew_viol_o[0] SHALL always be 0.

Verification (CHANNELS=4, SETUP_CYC=3, HOLD_CYC=2, SKEW_CYC=4, CNT_W=4, DATA_EDGE=0)
REQ-035 data_i[1] toggles at cycle 10, ref_i[1] rises at 12 -> setup_viol_o[1] pulses at 13, count1 = 1, sticky_o[1] = 1; ref at 13 instead -> no pulse.
REQ-036 ref_i[2] rises at 20, data_i[2] toggles at 22 -> hold_viol_o[2] pulses at 23; a toggle at 23 only -> no pulse.
REQ-037 data_i[0] and ref_i[0] edges both at 30 -> setup_viol_o[0] at 31, hold_viol_o[0] stays 0.
REQ-038 17 setup violations on channel 3 -> count3 = 15; clr_i for one cycle -> count3 = 0 and sticky_o[3] = 0.
REQ-039 rst_n pulsed low at cycle 51 after ref_i[1] rose at 50, with data_i all 1 at release -> no violations and counts stay 0.
REQ-040 Macro defined: ref_i[0] at 40, ref_i[1] at 42, ref_i[3] at 44, ref_i[2] none -> only skew_viol_o[2] pulses, at 45.
